sr_ff_checker: RTL
==================

Name: sr_ff_checker

Overview:
- Synthesizable self-checking monitor for a clocked SR flip-flop. It observes the S/R stimulus and the Q/Qn responses, which makes it the reading end of the SR flip-flop interface that benches and BIST logic drive.
- Keeps a reference model of the flip-flop. On every enabled edge it compares the flip-flop outputs against that model.
- Reports per-cycle error pulses, a sticky fail flag, and saturating error, invalid-input and check counters.

Parameters:
- CNT_W, 8, width of err_count, inv_count and chk_count (≥2).

Ports:
- clk  in  1  rising-edge clock, shared with the observed flip-flop.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  checker enable; when 0 the checker ignores its inputs.
- clr  in  1  synchronous clear of the counters and error_sticky.
- s  in  1  S input applied to the flip-flop.
- r  in  1  R input applied to the flip-flop.
- q  in  1  flip-flop Q output.
- qn  in  1  flip-flop Qn output.
- model_valid  out  1  1 while the reference model holds a known state.
- exp_q  out  1  reference-model Q.
- error_pulse  out  1  one-cycle flag for a mismatch detected on the previous edge.
- error_sticky  out  1  set on any mismatch; held until clr or reset.
- err_count  out  CNT_W  saturating mismatch count.
- inv_count  out  CNT_W  saturating count of S=R=1 events.
- chk_count  out  CNT_W  saturating count of comparisons performed.

Behaviour:
- Reset (rst_n=0, asynchronous): state=UNKNOWN, exp_q=0, cmp_valid=0. All outputs are 0.
- States:
  - UNKNOWN: model_valid=0. Entered at reset and after S=R=1.
  - TRACK: model_valid=1.
- Timing model: the flip-flop updates Q at edge k from the s/r values sampled at edge k. The checker samples q/qn at edge k+1 and compares them against exp_q as set at edge k. Check latency is one cycle; error_pulse rises after edge k+1.
- At each rising edge with en=1, in this order:
  1. Compare. If cmp_valid=1: mismatch = (q≠exp_q) OR (qn≠~exp_q). error_pulse<=mismatch. chk_count+1 (saturating at all-ones). On mismatch, err_count+1 (saturating) and error_sticky<=1. If cmp_valid=0, error_pulse<=0.
  2. Model update from s,r:
     - 10: exp_q<=1, state<=TRACK.
     - 01: exp_q<=0, state<=TRACK.
     - 00: hold exp_q and state.
     - 11: state<=UNKNOWN, exp_q holds, inv_count+1 (saturating).
  3. cmp_valid<=1 iff the next state is TRACK.
- At each rising edge with en=0: state and exp_q hold; cmp_valid<=0; error_pulse<=0; counters and sticky hold. After re-enable, the first enabled edge performs no compare.
- clr=1 at an edge: err_count, inv_count and chk_count <=0, and error_sticky<=0. clr takes priority over increments and sticky set on the same edge. error_pulse still reflects that edge's comparison. The model, state and cmp_valid are unaffected.
- Saturation: counters stop at 2^CNT_W−1 and never wrap.
- Reset mid-operation: everything returns to reset values immediately. The first check happens only after a set or reset input has been applied and one further enabled edge has occurred.
- While in UNKNOWN, no Q value is ever flagged, because the flip-flop is unreset and a Q state after S=R=1 is not defined.

Test Plan:
1. Reset, en=1, apply s/r=10, then 01, then 00, each for one cycle, with a correct flip-flop -> model_valid=1 after the first edge; exp_q sequence 1,0,0; chk_count=3 after three further edges; err_count=0; error_pulse never asserted.
2. Apply s/r=10 with a faulty flip-flop whose q is stuck at 0 -> error_pulse=1 for exactly one cycle after the next edge; err_count=1; error_sticky=1 and stays 1 through following good cycles.
3. In TRACK, apply s/r=11, then 00 for three cycles -> model_valid=0; inv_count=1; chk_count does not advance during UNKNOWN; no errors flagged regardless of q. Then apply s/r=01 -> TRACK, and checks resume one edge later.
4. Force qn=q with correct q -> each checked edge flags a mismatch; err_count increments once per edge.
5. CNT_W=2 with continuous mismatches for 6 checked edges -> err_count saturates at 3. Then clr=1 on the same edge as a mismatch -> err_count=0, error_sticky=0, error_pulse=1.
6. Drop en for 2 cycles mid-stream with q corrupted, then raise en -> no errors while disabled and none on the first re-enabled edge. Comparison resumes on the second edge. Assert rst_n low mid-cycle -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sr_ff_checker.sv
// sr_ff_checker: monitor for a clocked SR flip-flop. Tracks a reference
// model of the flip-flop and compares the observed Q/Qn against it one
// cycle later, reporting pulses, a sticky flag and saturating counters.
module sr_ff_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qn,
  output logic             model_valid,
  output logic             exp_q,
  output logic             error_pulse,
  output logic             error_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] inv_count,
  output logic [CNT_W-1:0] chk_count
);

  typedef enum logic {UNKNOWN = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  logic             expq_q, cmp_valid_q, pulse_q, sticky_q, sticky_d;
  logic [CNT_W-1:0] err_q, inv_q, chk_q, err_d, inv_d, chk_d;
  logic             do_cmp, mismatch, inv_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Compare result and counter next-state; clr wins over any increment.
  always_comb begin
    do_cmp   = en && cmp_valid_q;
    mismatch = (q != expq_q) || (qn == expq_q);
    inv_evt  = en && s && r;
    err_d    = err_q;
    inv_d    = inv_q;
    chk_d    = chk_q;
    sticky_d = sticky_q;
    if (do_cmp) begin
      chk_d = sat_inc(chk_q);
      if (mismatch) begin
        err_d    = sat_inc(err_q);
        sticky_d = 1'b1;
      end
    end
    if (inv_evt) inv_d = sat_inc(inv_q);
    if (clr) begin
      err_d    = '0;
      inv_d    = '0;
      chk_d    = '0;
      sticky_d = 1'b0;
    end
  end

  // Reference model FSM, compare-enable and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNKNOWN;
      expq_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else if (en) begin
      pulse_q <= cmp_valid_q && mismatch;
      unique case ({s, r})
        2'b10: begin
          expq_q      <= 1'b1;
          state_q     <= TRACK;
          cmp_valid_q <= 1'b1;
        end
        2'b01: begin
          expq_q      <= 1'b0;
          state_q     <= TRACK;
          cmp_valid_q <= 1'b1;
        end
        2'b11: begin
          state_q     <= UNKNOWN;
          cmp_valid_q <= 1'b0;
        end
        default: cmp_valid_q <= (state_q == TRACK);
      endcase
    end else begin
      // Disabled edges break the compare pipeline: the first enabled edge
      // afterwards only re-arms it.
      cmp_valid_q <= 1'b0;
      pulse_q     <= 1'b0;
    end
  end

  // Counters and sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= '0;
      inv_q    <= '0;
      chk_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      err_q    <= err_d;
      inv_q    <= inv_d;
      chk_q    <= chk_d;
      sticky_q <= sticky_d;
    end
  end

  assign model_valid  = (state_q == TRACK);
  assign exp_q        = expq_q;
  assign error_pulse  = pulse_q;
  assign error_sticky = sticky_q;
  assign err_count    = err_q;
  assign inv_count    = inv_q;
  assign chk_count    = chk_q;

endmodule
